// File: rtl/doorbell_write_arbiter.sv
// Round-robin arbiter that shares one PCIe posted-write (doorbell) channel among NUM_REQ requesters.
// Optional WRITE-state watchdog is enabled by defining DBARB_TIMEOUT_EN.
module doorbell_write_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ*64-1:0]   s_phys_addr_i,
    input  logic [NUM_REQ*32-1:0]   s_tail_pointer_i,
    input  logic [NUM_REQ-1:0]      s_pcie_write_i,
    output logic [NUM_REQ-1:0]      s_pcie_write_ack_o,
    output logic [63:0]             m_phys_addr_o,
    output logic [31:0]             m_tail_pointer_o,
    output logic                    m_pcie_write_o,
    input  logic                    m_pcie_write_ack_i,
    output logic [2:0]              grant_id_o,
    output logic                    err_timeout_o
);

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t               state_q, state_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           grant_q, grant_d;
    logic [63:0]          addr_q, addr_d;
    logic [31:0]          tp_q, tp_d;
    logic                 wr_q, wr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;
`ifdef DBARB_TIMEOUT_EN
    logic [31:0]          cnt_q, cnt_d;
`endif

    // Round-robin pick: lowest set index at or above rr_ptr wins, otherwise wrap to lowest set index.
    logic       hi_found, lo_found;
    logic [2:0] hi_win, lo_win, win;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (s_pcie_write_i[i]) begin
                lo_found = 1'b1;
                lo_win   = 3'(i);
                if (3'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_win   = 3'(i);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        tp_d     = tp_q;
        wr_d     = wr_q;
        ack_d    = '0;
        err_d    = err_q;
`ifdef DBARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (lo_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (3'(i) == win) begin
                            addr_d = s_phys_addr_i[i*64 +: 64];
                            tp_d   = s_tail_pointer_i[i*32 +: 32];
                        end
                    end
                    grant_d  = win;
                    wr_d     = 1'b1;
                    rr_ptr_d = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
                    state_d  = WRITE;
`ifdef DBARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            WRITE: begin
                if (m_pcie_write_ack_i) begin
                    wr_d    = 1'b0;
                    state_d = RESP;
                    for (int i = 0; i < NUM_REQ; i++)
                        if (3'(i) == grant_q) ack_d[i] = 1'b1;
`ifdef DBARB_TIMEOUT_EN
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    // Abort still acks the requester so it can move on.
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                    for (int i = 0; i < NUM_REQ; i++)
                        if (3'(i) == grant_q) ack_d[i] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            tp_q     <= '0;
            wr_q     <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
`ifdef DBARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            tp_q     <= tp_d;
            wr_q     <= wr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
`ifdef DBARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign s_pcie_write_ack_o = ack_q;
    assign m_phys_addr_o      = addr_q;
    assign m_tail_pointer_o   = tp_q;
    assign m_pcie_write_o     = wr_q;
    assign grant_id_o         = grant_q;
    assign err_timeout_o      = err_q;

endmodule
